alu_issue: RTL

Execute-stage front end that drives the shared combinational ALU. Accepts decoded R-type and immediate instructions over a valid/ready handshake and forms ALU operands: operand muxing, immediate extension and shift-amount routing. Registers the ALU result and its flags into a result stage for writeback. Sits between the decode stage and the writeback/SPI-visible register file; it is the initiator to the ALU's responder.

---
 rtl/alu_issue_pkg.sv | 53 +++++
 rtl/alu_issue_if.sv | 52 +++++
 rtl/alu_issue_opmux.sv | 50 +++++
 rtl/alu_issue.sv | 117 +++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared widths, MIPS funct encodings and stage payload types for the ALU issue block.
package alu_issue_pkg;

   localparam int unsigned W_CPU    = 32;
   localparam int unsigned W_OPCODE = 6;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned W_SHAMT  = 5;
   localparam int unsigned W_IMM    = 16;
   localparam int unsigned W_REG    = 5;

   localparam logic [W_OPCODE-1:0] FUNCT_SLL  = 6'h00;
   localparam logic [W_OPCODE-1:0] FUNCT_SRL  = 6'h02;
   localparam logic [W_OPCODE-1:0] FUNCT_SRAV = 6'h07;
   localparam logic [W_OPCODE-1:0] FUNCT_ADD  = 6'h20;
   localparam logic [W_OPCODE-1:0] FUNCT_ADDU = 6'h21;
   localparam logic [W_OPCODE-1:0] FUNCT_SUB  = 6'h22;
   localparam logic [W_OPCODE-1:0] FUNCT_SUBU = 6'h23;
   localparam logic [W_OPCODE-1:0] FUNCT_AND  = 6'h24;
   localparam logic [W_OPCODE-1:0] FUNCT_OR   = 6'h25;
   localparam logic [W_OPCODE-1:0] FUNCT_XOR  = 6'h26;
   localparam logic [W_OPCODE-1:0] FUNCT_SLT  = 6'h2A;
   localparam logic [W_OPCODE-1:0] FUNCT_SLTU = 6'h2B;

   typedef struct packed {
      logic [W_OPCODE-1:0] funct;
      logic [W_CPU-1:0]    rs_val;
      logic [W_CPU-1:0]    rt_val;
      logic [W_SHAMT-1:0]  shamt;
      logic [W_IMM-1:0]    imm;
      logic                use_imm;
      logic                imm_signed;
      logic [W_REG-1:0]    rd;
   } issue_t;

   typedef struct packed {
      logic [W_CPU-1:0] result;
      logic [W_REG-1:0] rd;
      logic             zero;
      logic             trap;
      logic             illegal;
   } result_t;

   function automatic logic funct_legal(input logic [W_OPCODE-1:0] f);
      case (f)
         FUNCT_SLL, FUNCT_SRL, FUNCT_SRAV, FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB,
         FUNCT_SUBU, FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_SLT, FUNCT_SLTU:
            funct_legal = 1'b1;
         default:
            funct_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue, ALU and result-stage signals of alu_issue; slave is the block's view, master the surroundings.
interface alu_issue_if;
   import alu_issue_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [W_OPCODE-1:0] in_funct;
   logic [W_CPU-1:0]    in_rs_val;
   logic [W_CPU-1:0]    in_rt_val;
   logic [W_SHAMT-1:0]  in_shamt;
   logic [W_IMM-1:0]    in_imm;
   logic                in_use_imm;
   logic                in_imm_signed;
   logic [W_REG-1:0]    in_rd;

   logic [W_OPCODE-1:0] alu_op;
   logic [W_CPU-1:0]    alu_a;
   logic [W_CPU-1:0]    alu_b;
   logic [W_CPU-1:0]    alu_r;
   logic                alu_overflow;
   logic                alu_zero;

   logic                out_valid;
   logic                out_ready;
   logic [W_CPU-1:0]    out_result;
   logic [W_REG-1:0]    out_rd;
   logic                out_zero;
   logic                out_trap;
   logic                out_illegal;
   logic [CNT_W-1:0]    trap_count;

   modport slave (
      input  in_valid, in_funct, in_rs_val, in_rt_val, in_shamt, in_imm,
             in_use_imm, in_imm_signed, in_rd,
      output in_ready,
      output alu_op, alu_a, alu_b,
      input  alu_r, alu_overflow, alu_zero,
      output out_valid, out_result, out_rd, out_zero, out_trap, out_illegal, trap_count,
      input  out_ready
   );

   modport master (
      output in_valid, in_funct, in_rs_val, in_rt_val, in_shamt, in_imm,
             in_use_imm, in_imm_signed, in_rd,
      input  in_ready,
      input  alu_op, alu_a, alu_b,
      output alu_r, alu_overflow, alu_zero,
      input  out_valid, out_result, out_rd, out_zero, out_trap, out_illegal, trap_count,
      output out_ready
   );

endinterface

// File: rtl/alu_issue_opmux.sv
// ALU operand selection, immediate extension and legal-funct decode for an issued instruction.
module alu_issue_opmux
   import alu_issue_pkg::*;
(
   input  logic                valid_i,
   input  logic [W_OPCODE-1:0] funct_i,
   input  logic [W_CPU-1:0]    rs_i,
   input  logic [W_CPU-1:0]    rt_i,
   input  logic [W_SHAMT-1:0]  shamt_i,
   input  logic [W_IMM-1:0]    imm_i,
   input  logic                use_imm_i,
   input  logic                imm_signed_i,
   output logic [W_OPCODE-1:0] alu_op_c_o,
   output logic [W_CPU-1:0]    alu_a_c_o,
   output logic [W_CPU-1:0]    alu_b_c_o,
   output logic                illegal_c_o
);

   logic [W_CPU-1:0] imm_ext_c;

   assign imm_ext_c = imm_signed_i ? {{(W_CPU-W_IMM){imm_i[W_IMM-1]}}, imm_i}
                                   : {{(W_CPU-W_IMM){1'b0}}, imm_i};

   // An empty issue slot presents a quiet all-zero operation to the ALU.
   always_comb begin
      alu_op_c_o  = '0;
      alu_a_c_o   = '0;
      alu_b_c_o   = '0;
      illegal_c_o = 1'b0;
      if (valid_i) begin
         alu_op_c_o  = funct_i;
         illegal_c_o = !funct_legal(funct_i);
         case (funct_i)
            FUNCT_SLL, FUNCT_SRL: begin
               alu_a_c_o = rt_i;
               alu_b_c_o = W_CPU'(shamt_i);
            end
            FUNCT_SRAV: begin
               alu_a_c_o = rs_i;
               alu_b_c_o = rt_i;
            end
            default: begin
               alu_a_c_o = rs_i;
               alu_b_c_o = use_imm_i ? imm_ext_c : rt_i;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_issue.sv
// Two-stage execute front end: issue register feeding the external ALU, result register toward writeback.
module alu_issue
   import alu_issue_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   alu_issue_if.slave  bus
);

   logic             s1_full_q, s1_full_d;
   issue_t           s1_q, s1_d;
   logic             out_valid_q, out_valid_d;
   result_t          s2_q, s2_d;
   logic [CNT_W-1:0] trap_count_q, trap_count_d;

   logic                s2_free_c, advance_c, in_ready_c, accept_c;
   logic [W_OPCODE-1:0] alu_op_c;
   logic [W_CPU-1:0]    alu_a_c, alu_b_c;
   logic                illegal_c, trap_c;

   alu_issue_opmux u_opmux (
      .valid_i      (s1_full_q),
      .funct_i      (s1_q.funct),
      .rs_i         (s1_q.rs_val),
      .rt_i         (s1_q.rt_val),
      .shamt_i      (s1_q.shamt),
      .imm_i        (s1_q.imm),
      .use_imm_i    (s1_q.use_imm),
      .imm_signed_i (s1_q.imm_signed),
      .alu_op_c_o   (alu_op_c),
      .alu_a_c_o    (alu_a_c),
      .alu_b_c_o    (alu_b_c),
      .illegal_c_o  (illegal_c)
   );

   assign bus.alu_op = alu_op_c;
   assign bus.alu_a  = alu_a_c;
   assign bus.alu_b  = alu_b_c;

   assign s2_free_c  = !out_valid_q || bus.out_ready;
   assign advance_c  = s1_full_q && s2_free_c;
   assign in_ready_c = !s1_full_q || s2_free_c;
   assign accept_c   = bus.in_valid && in_ready_c;

   // Only signed ADD/SUB trap; SUB overflow is derived locally from operand and result signs.
   always_comb begin
      trap_c = 1'b0;
      if (s1_q.funct == FUNCT_ADD) begin
         trap_c = bus.alu_overflow;
      end else if (s1_q.funct == FUNCT_SUB) begin
         trap_c = (alu_a_c[W_CPU-1] != alu_b_c[W_CPU-1]) &&
                  (bus.alu_r[W_CPU-1] != alu_a_c[W_CPU-1]);
      end
   end

   always_comb begin
      s1_full_d    = s1_full_q;
      s1_d         = s1_q;
      out_valid_d  = out_valid_q;
      s2_d         = s2_q;
      trap_count_d = trap_count_q;

      if (accept_c) begin
         s1_full_d = 1'b1;
         s1_d      = '{funct:      bus.in_funct,
                       rs_val:     bus.in_rs_val,
                       rt_val:     bus.in_rt_val,
                       shamt:      bus.in_shamt,
                       imm:        bus.in_imm,
                       use_imm:    bus.in_use_imm,
                       imm_signed: bus.in_imm_signed,
                       rd:         bus.in_rd};
      end else if (advance_c) begin
         s1_full_d = 1'b0;
      end

      if (advance_c) begin
         out_valid_d  = 1'b1;
         s2_d.result  = illegal_c ? '0 : bus.alu_r;
         s2_d.rd      = (trap_c || illegal_c) ? '0 : s1_q.rd;
         s2_d.zero    = bus.alu_zero;
         s2_d.trap    = trap_c;
         s2_d.illegal = illegal_c;
         if ((trap_c || illegal_c) && (trap_count_q != '1)) begin
            trap_count_d = trap_count_q + CNT_W'(1);
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_full_q    <= 1'b0;
         s1_q         <= '0;
         out_valid_q  <= 1'b0;
         s2_q         <= '0;
         trap_count_q <= '0;
      end else begin
         s1_full_q    <= s1_full_d;
         s1_q         <= s1_d;
         out_valid_q  <= out_valid_d;
         s2_q         <= s2_d;
         trap_count_q <= trap_count_d;
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_result  = s2_q.result;
   assign bus.out_rd      = s2_q.rd;
   assign bus.out_zero    = s2_q.zero;
   assign bus.out_trap    = s2_q.trap;
   assign bus.out_illegal = s2_q.illegal;
   assign bus.trap_count  = trap_count_q;

endmodule
